// File: rtl/butterfly_pkg.sv
// butterfly_pkg: shared types for the ButterFly core memory-port arbiter.
// Holds the arbiter FSM states, owner encoding and starvation counter width.
package butterfly_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LSU
    } arb_owner_e;

    localparam int BF_STARVE_CNT_W = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and LSU, one access in flight.
// Optional IF starvation guard enabled by defining BF_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import butterfly_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [DATA_W/8-1:0] lsu_be_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    output logic                lsu_gnt_o,
    output logic                lsu_rvalid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                mem_busy_o
);

    localparam int BE_W = DATA_W / 8;

    // The guard counter must be able to reach STARVE_MAX.
    if (STARVE_MAX < 1 || STARVE_MAX >= (1 << BF_STARVE_CNT_W)) begin : g_bad_starve
        $error("STARVE_MAX out of range for BF_STARVE_CNT_W");
    end

    arb_state_e state;
    arb_owner_e owner;

    logic              any_req;
    logic              pick_lsu;
    logic              arb_fire;
    logic              in_req;
    logic              in_wait;
    logic              cmd_we;
    logic [BE_W-1:0]   cmd_be;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    assign any_req = if_req_i | lsu_req_i;
    assign in_req  = (state == ARB_REQ);
    assign in_wait = (state == ARB_WAIT);

    // Arbitration happens from IDLE, or back-to-back as a response retires.
    assign arb_fire = any_req
                    & ((state == ARB_IDLE) | (in_wait & mem_rvalid_i));

`ifdef BF_ARB_STARVE_GUARD_EN
    logic [BF_STARVE_CNT_W-1:0] starve_cnt;
    logic                       force_if;

    assign force_if = if_req_i
                    & (starve_cnt == BF_STARVE_CNT_W'(STARVE_MAX));
    assign pick_lsu = lsu_req_i & ~force_if;

    // Count LSU wins that left IF waiting; any IF win clears the count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (arb_fire) begin
            if (!pick_lsu) begin
                starve_cnt <= '0;
            end else if (if_req_i) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    assign pick_lsu = lsu_req_i;
`endif

    // Command of the arbitration winner; IF fetches are full-word reads.
    always_comb begin
        cmd_we    = 1'b0;
        cmd_be    = '1;
        cmd_addr  = if_addr_i;
        cmd_wdata = '0;
        if (pick_lsu) begin
            cmd_we    = lsu_we_i;
            cmd_be    = lsu_be_i;
            cmd_addr  = lsu_addr_i;
            cmd_wdata = lsu_wdata_i;
        end
    end

    // Arbiter FSM with registered memory-side command.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= ARB_IDLE;
            owner       <= OWN_IF;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (arb_fire) begin
                        state <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (mem_rvalid_i) begin
                        state <= arb_fire ? ARB_REQ : ARB_IDLE;
                    end
                end
                default: begin
                    mem_req_o <= 1'b0;
                    state     <= ARB_IDLE;
                end
            endcase
            if (arb_fire) begin
                owner       <= pick_lsu ? OWN_LSU : OWN_IF;
                mem_req_o   <= 1'b1;
                mem_we_o    <= cmd_we;
                mem_be_o    <= cmd_be;
                mem_addr_o  <= cmd_addr;
                mem_wdata_o <= cmd_wdata;
            end
        end
    end

    assign if_gnt_o     = in_req  & (owner == OWN_IF)  & mem_gnt_i;
    assign lsu_gnt_o    = in_req  & (owner == OWN_LSU) & mem_gnt_i;
    assign if_rvalid_o  = in_wait & (owner == OWN_IF)  & mem_rvalid_i;
    assign lsu_rvalid_o = in_wait & (owner == OWN_LSU) & mem_rvalid_i;

    assign if_rdata_o  = mem_rdata_i;
    assign lsu_rdata_o = mem_rdata_i;

    // Stall the pipeline while an LSU access is unaccepted or unanswered.
    assign mem_busy_o = (lsu_req_i & ~lsu_gnt_o)
                      | ((owner == OWN_LSU) & in_wait & ~mem_rvalid_i);

endmodule
